// File: rtl/efpga_dsp_pkg.sv
// Shared definitions for the eFPGA DSP slice: mode encoding and saturation constants.
package efpga_dsp_pkg;

  typedef enum logic [1:0] {
    MODE_MULT = 2'b00,
    MODE_ADD  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_MACC = 2'b11
  } dsp_mode_e;

  localparam int SAT_MAX_W = 128;

  // Clamp constant for a result of the given width; callers slice the low bits.
  function automatic logic [SAT_MAX_W-1:0] sat_clamp(input int width, input bit is_signed,
                                                     input bit want_max);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < width) begin
        if (!is_signed)          r[i] = want_max;
        else if (i == width - 1) r[i] = !want_max;
        else                     r[i] = want_max;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/efpga_dsp_slice_stage.sv
// Enable-gated, async-reset register with a valid bit; one pipeline stage of the DSP slice.
module efpga_dsp_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Data advances on every enabled cycle, valid or not; r_valid tags it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/efpga_dsp_slice.sv
// Runtime-selectable DSP slice: multiply, add, accumulate, multiply-accumulate.
// Handshake: in_valid qualifies a/b/mode/clr; no backpressure; en=0 freezes every stage.
module efpga_dsp_slice
  import efpga_dsp_pkg::*;
#(
  parameter int INPUT_WIDTH  = 18,
  parameter int OUTPUT_WIDTH = 40,
  parameter int REG_IN       = 1,
  parameter int REG_PIPE     = 1,
  parameter int SIGNED       = 0,
  parameter int SATURATE     = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [1:0]              mode,
  input  logic                    clr,
  input  logic [INPUT_WIDTH-1:0]  a,
  input  logic [INPUT_WIDTH-1:0]  b,
  output logic                    out_valid,
  output logic [OUTPUT_WIDTH-1:0] y,
  output logic                    ovf
);

  localparam int IW  = INPUT_WIDTH;
  localparam int OW  = OUTPUT_WIDTH;
  localparam int S1W = 3 + 2 * IW;
  localparam int S2W = 3 + OW;
  localparam bit SG  = (SIGNED != 0);
  localparam bit SAT = (SATURATE != 0);

  localparam logic [SAT_MAX_W-1:0] SAT_POS_FULL = sat_clamp(OW, SG, 1'b1);
  localparam logic [SAT_MAX_W-1:0] SAT_NEG_FULL = sat_clamp(OW, SG, 1'b0);
  localparam logic [OW-1:0]        SAT_POS      = SAT_POS_FULL[OW-1:0];
  localparam logic [OW-1:0]        SAT_NEG      = SAT_NEG_FULL[OW-1:0];

  logic           w_s1_valid;
  logic [S1W-1:0] w_s1_data;
  logic [1:0]     w_s1_mode;
  logic           w_s1_clr;
  logic [IW-1:0]  w_s1_a;
  logic [IW-1:0]  w_s1_b;

  generate
    if (REG_IN != 0) begin : g_in_reg
      efpga_dsp_stage #(.WIDTH(S1W)) u_in_reg (
        .clk    (clk),
        .resetn (resetn),
        .i_en   (en),
        .i_valid(in_valid),
        .i_data ({mode, clr, a, b}),
        .o_valid(w_s1_valid),
        .o_data (w_s1_data)
      );
    end else begin : g_in_bypass
      assign w_s1_valid = in_valid;
      assign w_s1_data  = {mode, clr, a, b};
    end
  endgenerate

  assign {w_s1_mode, w_s1_clr, w_s1_a, w_s1_b} = w_s1_data;

  // Operands widened to OW first, so the truncated product/sum is already extended.
  logic [OW-1:0] w_a_ext;
  logic [OW-1:0] w_b_ext;
  logic [OW-1:0] w_prod;
  logic [OW-1:0] w_add;
  logic [OW-1:0] w_term;

  assign w_a_ext = {{(OW - IW){SG & w_s1_a[IW-1]}}, w_s1_a};
  assign w_b_ext = {{(OW - IW){SG & w_s1_b[IW-1]}}, w_s1_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_add   = w_a_ext + w_b_ext;

  always_comb begin
    w_term = w_prod;
    case (w_s1_mode)
      MODE_ADD: w_term = w_add;
      MODE_ACC: w_term = w_a_ext;
      default:  w_term = w_prod;
    endcase
  end

  logic           w_s2_valid;
  logic [S2W-1:0] w_s2_data;
  logic [1:0]     w_s2_mode;
  logic           w_s2_clr;
  logic [OW-1:0]  w_s2_term;

  generate
    if (REG_PIPE != 0) begin : g_pipe_reg
      efpga_dsp_stage #(.WIDTH(S2W)) u_pipe_reg (
        .clk    (clk),
        .resetn (resetn),
        .i_en   (en),
        .i_valid(w_s1_valid),
        .i_data ({w_s1_mode, w_s1_clr, w_term}),
        .o_valid(w_s2_valid),
        .o_data (w_s2_data)
      );
    end else begin : g_pipe_bypass
      assign w_s2_valid = w_s1_valid;
      assign w_s2_data  = {w_s1_mode, w_s1_clr, w_term};
    end
  endgenerate

  assign {w_s2_mode, w_s2_clr, w_s2_term} = w_s2_data;

  logic          r_out_valid;
  logic [OW-1:0] r_y;
  logic          r_ovf;
  logic          w_acc;
  logic [OW-1:0] w_base;
  logic [OW:0]   w_sum;
  logic          w_ovf_now;
  logic [OW-1:0] w_y_next;

  // Accumulating modes have mode[1] set; clr restarts from zero.
  assign w_acc     = w_s2_mode[1];
  assign w_base    = (w_acc && !w_s2_clr) ? r_y : '0;
  assign w_sum     = {SG & w_base[OW-1], w_base} + {SG & w_s2_term[OW-1], w_s2_term};
  assign w_ovf_now = w_acc & (SG ? (w_sum[OW] ^ w_sum[OW-1]) : w_sum[OW]);

  always_comb begin
    w_y_next = w_sum[OW-1:0];
    if (w_ovf_now && SAT) begin
      w_y_next = (SG && w_sum[OW]) ? SAT_NEG : SAT_POS;
    end
  end

  // out_valid marks that y changed on the most recent edge; a disabled edge clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_ovf       <= 1'b0;
    end else if (en) begin
      r_out_valid <= w_s2_valid;
      if (w_s2_valid) begin
        r_y <= w_y_next;
        if (w_ovf_now)              r_ovf <= 1'b1;
        else if (w_acc && w_s2_clr) r_ovf <= 1'b0;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign ovf       = r_ovf;

endmodule
